gf180_ram_banked: RTL and testbench
===================================

Name: gf180_ram_banked

Overview:
Parametrised successor to the single 256x8 SRAM macro wrapper. It tiles gf180mcu_fd_ip_sram__sram256x8m8wm1 macros into BANKS x DATA_BYTES, giving a (BANKS*256)-word x (8*DATA_BYTES)-bit memory. It adds:
- a valid/ready request port with per-byte enables
- a registered one-cycle read response
- an optional hardware zero-clear sweep after reset, needed because the macros have no reset

It sits between core/fabric logic and the raw SRAM macros.

Parameters:
DATA_BYTES, 4, bytes per word; word width W = 8*DATA_BYTES; one macro per byte lane per bank.
BANKS, 2, number of 256-word banks (1..8, need not be a power of two); AW = 8 + clog2(BANKS), and AW = 8 when BANKS = 1.
CLEAR_ON_RESET, 1, when 1, zero all macros after reset before accepting requests.

Ports:
CLK  input  1  clock; macros clocked directly from it.
RST_N  input  1  asynchronous active-low reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  block can accept a request this cycle.
REQ_WRITE  input  1  1 = write, 0 = read.
REQ_ADDR  input  AW  word address; [7:0] = row, [AW-1:8] = bank index.
REQ_WDATA  input  W  write data.
REQ_BE  input  DATA_BYTES  byte enables for writes, active high.
RSP_VALID  output  1  one-cycle pulse: RSP_RDATA carries read data.
RSP_RDATA  output  W  read data; holds last value when RSP_VALID = 0.
BUSY  output  1  clear sweep in progress.

Behaviour:
- FSM states: CLEAR, RUN.
- Async reset (RST_N low) sets:
  - state = CLEAR if CLEAR_ON_RESET else RUN
  - clear counter = 0, RSP_VALID = 0, RSP_RDATA holding register = 0, registered bank index = 0
- While RST_N is low, all macro CEN = 1 (combinational from state/reset). No macro access occurs during reset.
- Outputs in reset:
  - REQ_READY = 0, BUSY = CLEAR_ON_RESET, RSP_VALID = 0, RSP_RDATA = 0.
- CLEAR state:
  - Every cycle, write zero to row = counter in all banks and all lanes: CEN = 0, GWEN = 0, WEN = 0, D = 0.
  - Counter increments each cycle. When counter = 255 the write occurs and state goes to RUN.
  - REQ_READY first asserts 256 rising edges after RST_N release. BUSY = 1 and REQ_READY = 0 throughout CLEAR. Requests are ignored.
- RUN state:
  - REQ_READY = 1 continuously (no stalls). Accept = REQ_VALID & REQ_READY.
  - On accept, only the addressed bank sees CEN = 0. All other banks see CEN = 1. A = REQ_ADDR[7:0].
  - Write: GWEN = 0, D = REQ_WDATA lane slice, lane WEN = all 0 if REQ_BE[i] else all 1. No response is generated.
  - A write with REQ_BE = 0 still strobes CEN but modifies nothing.
  - Read: GWEN = 1. Bank index and a read flag are registered.
  - On the next cycle, RSP_VALID = 1 and RSP_RDATA = the selected bank's macro Q lanes (combinational mux on the registered bank index). The holding register captures the same value on that edge.
  - Otherwise RSP_RDATA = holding register.
- Read latency is exactly 1 cycle. Back-to-back reads every cycle are allowed, giving RSP_VALID high continuously. No response backpressure.
- Read of an address written in the previous cycle returns the new data. Macro write-then-read ordering is natural; no bypass is needed.
- Bank index >= BANKS (non-power-of-two BANKS):
  - write: no macro enabled, silently dropped
  - read: RSP_VALID still pulses next cycle with RSP_RDATA = 0
- Reset asserted mid-sweep or with a read outstanding:
  - pending response is dropped (RSP_VALID stays 0)
  - sweep restarts from row 0 after release
- Byte lane i = bits [8i+7:8i] throughout.

Test Plan:
- CLEAR_ON_RESET=1, BANKS=2, DATA_BYTES=4:
  - release RST_N, count edges -> BUSY = 1 and REQ_READY = 0 for exactly 256 edges, then REQ_READY = 1 and BUSY = 0.
  - Read addr 0x000, 0x1FF -> RSP_VALID one cycle later, RSP_RDATA = 0x00000000.
- Write 0x1A5 = 0xDEADBEEF with BE=1111, then read 0x1A5 -> RSP_RDATA = 0xDEADBEEF.
  - Read 0x0A5 -> 0x00000000 (bank isolation).
- Write 0x010 = 0xDEADBEEF, then write 0x010 = 0x11223344 with BE=0101, then read -> 0xDE22BE44.
  - Write with BE=0000 -> data unchanged.
- Back-to-back reads on consecutive cycles:
  - 0x001, 0x101, 0x002 preloaded 1, 2, 3 -> RSP_VALID high 3 cycles with 1, 2, 3 in order.
  - RSP_RDATA stays at 3 after RSP_VALID drops.
- BANKS=3, read addr 0x3xx -> RSP_VALID pulse with RSP_RDATA = 0; write 0x3xx -> no macro CEN low.
- Assert RST_N low at sweep row 100, release -> sweep restarts at row 0, 256 edges to READY.
  - Issue a read, then reset on the response cycle -> RSP_VALID = 0.
  - With CLEAR_ON_RESET=0 -> REQ_READY = 1 immediately after release.

Source files
------------

// File: rtl/gf180_ram_banked.sv
// +--------------------------------------------------------------------------+
// | gf180_ram_banked: BANKS x DATA_BYTES tiling of 256x8 SRAM macros with a  |
// | valid/ready port, 1-cycle read response and optional zero sweep.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

// Behavioural view of the 256x8 macro; the foundry model replaces it in signoff.
module gf180mcu_fd_ip_sram__sram256x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [7:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);
  logic [7:0] r_mem [256];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
      else       Q        <= r_mem[A];
    end
  end
endmodule

module gf180_ram_banked #(
  parameter  int DATA_BYTES     = 4,
  parameter  int BANKS          = 2,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int W              = 8 * DATA_BYTES,
  localparam int BW             = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int AW             = (BANKS > 1) ? 8 + $clog2(BANKS) : 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [AW-1:0]         REQ_ADDR,
  input  logic [W-1:0]          REQ_WDATA,
  input  logic [DATA_BYTES-1:0] REQ_BE,
  output logic                  RSP_VALID,
  output logic [W-1:0]          RSP_RDATA,
  output logic                  BUSY
);
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic [7:0]               r_cnt;
  logic                     r_rd_pend;
  logic [BW-1:0]            r_rd_bank;
  logic [W-1:0]             r_hold;
  logic [BW-1:0]            w_bank;
  logic [BANKS-1:0][W-1:0]  w_q;
  logic [W-1:0]             w_rsel;
  logic                     w_clear;
  logic                     w_accept;

  generate
    if (BANKS > 1) begin : g_bank_idx
      assign w_bank = REQ_ADDR[AW-1:8];
    end else begin : g_single_bank
      assign w_bank = '0;
    end
  endgenerate

  assign w_clear   = (r_state == S_CLEAR);
  // Ready must drop during reset even when reset lands directly in RUN.
  assign REQ_READY = (r_state == S_RUN) && RST_N;
  assign BUSY      = w_clear;
  assign w_accept  = REQ_VALID && REQ_READY;

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear && (r_cnt == 8'hFF)) w_state_nxt = S_RUN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      r_cnt     <= 8'h00;
      r_rd_pend <= 1'b0;
      r_rd_bank <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_clear) r_cnt <= r_cnt + 8'd1;
      r_rd_pend <= w_accept && !REQ_WRITE;
      if (w_accept && !REQ_WRITE) r_rd_bank <= w_bank;
      if (r_rd_pend) r_hold <= w_rsel;
    end
  end

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      logic w_cen;
      assign w_cen = !(RST_N && (w_clear || (w_accept && (w_bank == BW'(b)))));
      for (genvar l = 0; l < DATA_BYTES; l++) begin : g_lane
        gf180mcu_fd_ip_sram__sram256x8m8wm1 u_sram (
          .CLK  (CLK),
          .CEN  (w_cen),
          .GWEN (w_clear ? 1'b0 : !REQ_WRITE),
          .WEN  ((w_clear || REQ_BE[l]) ? 8'h00 : 8'hFF),
          .A    (w_clear ? r_cnt : REQ_ADDR[7:0]),
          .D    (w_clear ? 8'h00 : REQ_WDATA[8*l +: 8]),
          .Q    (w_q[b][8*l +: 8])
        );
      end
    end
  endgenerate

  // Out-of-range bank indices match nothing and read back as zero.
  always_comb begin
    w_rsel = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (r_rd_bank == BW'(b)) w_rsel = w_q[b];
    end
  end

  assign RSP_VALID = r_rd_pend;
  assign RSP_RDATA = r_rd_pend ? w_rsel : r_hold;
endmodule

`default_nettype wire

// File: tb/tb_gf180_ram_banked.sv
// Bench for gf180_ram_banked: vector table, hand sequences and a random phase
// against an address-indexed memory model.
`default_nettype none

module tb_gf180_ram_banked;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: 2 banks, sweep enabled
  logic        rst0 = 1'b0, v0 = 1'b0, wr0 = 1'b0;
  logic [8:0]  a0 = '0;
  logic [31:0] wd0 = '0;
  logic [3:0]  be0 = '0;
  logic        rdy0, rv0, busy0;
  logic [31:0] rd0;

  // Instance 1: 3 banks, no sweep
  logic        rst1 = 1'b0, v1 = 1'b0, wr1 = 1'b0;
  logic [9:0]  a1 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0]  be1 = '0;
  logic        rdy1, rv1, busy1;
  logic [31:0] rd1;

  gf180_ram_banked #(.DATA_BYTES(4), .BANKS(2), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .CLK(clk), .RST_N(rst0), .REQ_VALID(v0), .REQ_READY(rdy0), .REQ_WRITE(wr0),
    .REQ_ADDR(a0), .REQ_WDATA(wd0), .REQ_BE(be0), .RSP_VALID(rv0),
    .RSP_RDATA(rd0), .BUSY(busy0));

  gf180_ram_banked #(.DATA_BYTES(4), .BANKS(3), .CLEAR_ON_RESET(1'b0)) u_dut1 (
    .CLK(clk), .RST_N(rst1), .REQ_VALID(v1), .REQ_READY(rdy1), .REQ_WRITE(wr1),
    .REQ_ADDR(a1), .REQ_WDATA(wd1), .REQ_BE(be1), .RSP_VALID(rv1),
    .RSP_RDATA(rd1), .BUSY(busy1));

  logic [31:0] mem [512];
  logic [31:0] hold_exp;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void mwrite(input logic [8:0] addr, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic void mclear();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
  endfunction

  // Count edges from release to READY while offering reads that must be ignored.
  task automatic wait_sweep(input string nm);
    int n = 0;
    int bad = 0;
    v0 = 1'b1; wr0 = 1'b0; a0 = 9'h0;
    while (!rdy0 && n < 400) begin
      if (!busy0 || rv0) bad++;
      tick();
      n++;
    end
    v0 = 1'b0;
    chk({nm, " edges to ready"}, 32'(n), 32'd256);
    chk({nm, " busy/rsp during sweep"}, 32'(bad), 32'd0);
    chk({nm, " busy after sweep"}, 32'(busy0), 32'd0);
  endtask

  task automatic req1(input bit wr, input logic [9:0] addr, input logic [31:0] d);
    v1 = 1'b1; wr1 = wr; a1 = addr; wd1 = d; be1 = 4'hF;
    tick();
    v1 = 1'b0;
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{0, 9'h000, 32'h0,        4'h0, 32'h00000000};
    vt[1] = '{0, 9'h1FF, 32'h0,        4'h0, 32'h00000000};
    vt[2] = '{1, 9'h1A5, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[3] = '{0, 9'h1A5, 32'h0,        4'h0, 32'hDEADBEEF};
    vt[4] = '{0, 9'h0A5, 32'h0,        4'h0, 32'h00000000};
    vt[5] = '{1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    vt[6] = '{1, 9'h010, 32'h11223344, 4'h5, 32'h0};
    vt[7] = '{0, 9'h010, 32'h0,        4'h0, 32'hDE22BE44};
    vt[8] = '{1, 9'h010, 32'hFFFFFFFF, 4'h0, 32'h0};
    vt[9] = '{0, 9'h010, 32'h0,        4'h0, 32'hDE22BE44};
    mclear();
    hold_exp = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst ready", 32'(rdy0), 32'd0);
    chk("rst busy", 32'(busy0), 32'd1);
    chk("rst rsp_valid", 32'(rv0), 32'd0);
    chk("rst rdata", rd0, 32'h0);

    rst0 = 1'b1;
    wait_sweep("sweep1");

    // Table vectors
    foreach (vt[i]) begin
      v0 = 1'b1; wr0 = vt[i].wr; a0 = vt[i].addr; wd0 = vt[i].wdata; be0 = vt[i].be;
      if (vt[i].wr) mwrite(vt[i].addr, vt[i].wdata, vt[i].be);
      tick();
      v0 = 1'b0;
      chk($sformatf("vec%0d rsp_valid", i), 32'(rv0), 32'(!vt[i].wr));
      if (!vt[i].wr) begin
        chk($sformatf("vec%0d rdata", i), rd0, vt[i].exp);
        hold_exp = vt[i].exp;
      end
      tick();
      chk($sformatf("vec%0d rsp_valid drop", i), 32'(rv0), 32'd0);
    end

    // Back-to-back reads across banks
    v0 = 1'b1; wr0 = 1'b1; be0 = 4'hF;
    a0 = 9'h001; wd0 = 32'd1; mwrite(a0, wd0, be0); tick();
    a0 = 9'h101; wd0 = 32'd2; mwrite(a0, wd0, be0); tick();
    a0 = 9'h002; wd0 = 32'd3; mwrite(a0, wd0, be0); tick();
    wr0 = 1'b0;
    a0 = 9'h001; tick();
    chk("b2b1 valid", 32'(rv0), 32'd1); chk("b2b1 data", rd0, 32'd1);
    a0 = 9'h101; tick();
    chk("b2b2 valid", 32'(rv0), 32'd1); chk("b2b2 data", rd0, 32'd2);
    a0 = 9'h002; tick();
    chk("b2b3 valid", 32'(rv0), 32'd1); chk("b2b3 data", rd0, 32'd3);
    v0 = 1'b0; tick();
    chk("b2b drop valid", 32'(rv0), 32'd0); chk("b2b hold data", rd0, 32'd3);
    hold_exp = 32'd3;

    // Random traffic against the address-indexed model
    for (int i = 0; i < 300; i++) begin
      logic ev;
      logic [31:0] ed;
      v0  = ($urandom_range(0, 3) != 0);
      wr0 = 1'($urandom_range(0, 1));
      a0  = {1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 7))};
      wd0 = $urandom;
      be0 = 4'($urandom_range(0, 15));
      ev = 1'b0;
      ed = hold_exp;
      if (v0 && !wr0) begin
        ev = 1'b1;
        ed = mem[a0];
      end else if (v0) begin
        mwrite(a0, wd0, be0);
      end
      tick();
      chk("rand rsp_valid", 32'(rv0), 32'(ev));
      chk("rand rdata", rd0, ed);
      hold_exp = ed;
    end
    v0 = 1'b0;

    // Reset landing on the response cycle drops the response
    v0 = 1'b1; wr0 = 1'b0; a0 = 9'h1A5;
    tick();
    v0 = 1'b0;
    rst0 = 1'b0;
    #1;
    chk("rst on rsp valid", 32'(rv0), 32'd0);
    chk("rst on rsp rdata", rd0, 32'h0);
    tick();
    rst0 = 1'b1;
    mclear();
    wait_sweep("sweep2");

    // Reset in the middle of the sweep restarts it
    v0 = 1'b1; wr0 = 1'b1; be0 = 4'hF; a0 = 9'h1C8; wd0 = 32'hCAFEF00D;
    tick();
    v0 = 1'b0;
    rst0 = 1'b0; tick(); rst0 = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    rst0 = 1'b0; #1;
    chk("midsweep rst busy", 32'(busy0), 32'd1);
    chk("midsweep rst ready", 32'(rdy0), 32'd0);
    tick();
    rst0 = 1'b1;
    wait_sweep("sweep3");
    v0 = 1'b1; wr0 = 1'b0; a0 = 9'h1C8;
    tick();
    v0 = 1'b0;
    chk("post sweep cleared", rd0, 32'h0);

    // Instance 1: no sweep, three banks
    chk("i1 rst ready", 32'(rdy1), 32'd0);
    chk("i1 rst busy", 32'(busy1), 32'd0);
    rst1 = 1'b1;
    #1;
    chk("i1 ready at release", 32'(rdy1), 32'd1);
    req1(1'b1, 10'h005, 32'hAAAA5555);
    req1(1'b1, 10'h105, 32'h12345678);
    req1(1'b1, 10'h205, 32'h0BADCAFE);
    req1(1'b1, 10'h305, 32'hFFFFFFFF);
    req1(1'b0, 10'h005, 32'h0);
    chk("i1 rd bank0", rd1, 32'hAAAA5555);
    req1(1'b0, 10'h305, 32'h0);
    chk("i1 oob valid", 32'(rv1), 32'd1);
    chk("i1 oob rdata", rd1, 32'h0);
    req1(1'b0, 10'h105, 32'h0);
    chk("i1 rd bank1", rd1, 32'h12345678);
    req1(1'b0, 10'h205, 32'h0);
    chk("i1 rd bank2", rd1, 32'h0BADCAFE);
    req1(1'b0, 10'h005, 32'h0);
    chk("i1 rd bank0 again", rd1, 32'hAAAA5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
